// File: rtl/snake_row_shifter.sv
// Row register with IDLE-time bit set/clear masks and a multi-cycle shift/rotate
// engine that moves the row one bit per clock.
module snake_row_shifter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  mask_set,
  input  logic [WIDTH-1:0]  mask_clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_rotate,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  row,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              state_dbg
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high exactly in IDLE and does not depend on cmd_valid.
  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SHIFT = 1'b1;

  logic              r_state;
  logic [STEP_W-1:0] r_cnt;
  logic              r_dir;
  logic              r_rot;
  logic [WIDTH-1:0]  r_row;
  logic              r_ovf;
  logic              r_done;

  logic [WIDTH-1:0]  w_row_left;
  logic [WIDTH-1:0]  w_row_right;
  logic [WIDTH-1:0]  w_row_shifted;
  logic              w_out_bit;
  logic              w_ovf_set;

  // The bit leaving the row either wraps to the opposite end or is replaced by 0.
  assign w_row_left    = {r_row[WIDTH-2:0], r_rot ? r_row[WIDTH-1] : 1'b0};
  assign w_row_right   = {r_rot ? r_row[0] : 1'b0, r_row[WIDTH-1:1]};
  assign w_row_shifted = r_dir ? w_row_left : w_row_right;
  assign w_out_bit     = r_dir ? r_row[WIDTH-1] : r_row[0];
  assign w_ovf_set     = (r_state == S_SHIFT) && !r_rot && w_out_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_rot   <= 1'b0;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_row <= (r_row & ~mask_clr) | mask_set;
          if (cmd_valid) begin
            r_dir <= cmd_dir;
            r_rot <= cmd_rotate;
            r_cnt <= cmd_steps;
            if (cmd_steps == '0) r_done  <= 1'b1;
            else                 r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_row <= w_row_shifted;
          r_cnt <= r_cnt - STEP_W'(1);
          if (r_cnt == STEP_W'(1)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A set event on the same edge as ovf_clr takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (ovf_clr)   r_ovf <= 1'b0;
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_SHIFT);
  assign row       = r_row;
  assign done      = r_done;
  assign overflow  = r_ovf;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_snake_row_shifter.sv
// Directed bench for snake_row_shifter (WIDTH=8, STEP_W=4); observed word is
// {busy, done, cmd_ready, overflow, row[7:0]}.
`timescale 1ns/1ps
module tb_snake_row_shifter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mask_set;
  logic [7:0] mask_clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [3:0] cmd_steps;
  logic       cmd_rotate;
  logic       ovf_clr;
  logic [7:0] row;
  logic       busy;
  logic       done;
  logic       overflow;
  logic       state_dbg;

  int total = 0;
  int bad   = 0;

  wire [11:0] w_obs = {busy, done, cmd_ready, overflow, row};

  snake_row_shifter #(.WIDTH(8), .STEP_W(4)) dut (
    .clk(clk), .reset(reset), .mask_set(mask_set), .mask_clr(mask_clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_rotate(cmd_rotate), .ovf_clr(ovf_clr),
    .row(row), .busy(busy), .done(done), .overflow(overflow),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input logic [7:0] v);
    mask_set = v;
    mask_clr = 8'hFF;
    tick();
    mask_set = 8'h00;
    mask_clr = 8'h00;
  endtask

  task automatic send_cmd(input logic dir, input logic [3:0] steps, input logic rot);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_steps  = steps;
    cmd_rotate = rot;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    if (w_obs !== {4'b0010, 8'h00}) begin
      $display("FAIL reset_async got=%h exp=%h", w_obs, {4'b0010, 8'h00}); bad++;
    end
    total++;
    tick();
    tick();
    if (w_obs !== {4'b0010, 8'h00}) begin
      $display("FAIL reset_held got=%h exp=%h", w_obs, {4'b0010, 8'h00}); bad++;
    end
    total++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mask_priority();
    mask_set = 8'h81;
    mask_clr = 8'h01;
    tick();
    mask_set = 8'h00;
    mask_clr = 8'h00;
    if (w_obs !== {4'b0010, 8'h81}) begin
      $display("FAIL mask_priority got=%h exp=%h", w_obs, {4'b0010, 8'h81}); bad++;
    end
    total++;
    mask_clr = 8'h80;
    tick();
    mask_clr = 8'h00;
    if (w_obs !== {4'b0010, 8'h01}) begin
      $display("FAIL mask_clear got=%h exp=%h", w_obs, {4'b0010, 8'h01}); bad++;
    end
    total++;
  endtask

  task automatic test_shift_left_ovf();
    load_row(8'hC0);
    send_cmd(1'b1, 4'd2, 1'b0);
    if (w_obs !== {4'b1000, 8'hC0}) begin
      $display("FAIL shl_accept got=%h exp=%h", w_obs, {4'b1000, 8'hC0}); bad++;
    end
    total++;
    tick();
    if (w_obs !== {4'b1001, 8'h80}) begin
      $display("FAIL shl_step1 got=%h exp=%h", w_obs, {4'b1001, 8'h80}); bad++;
    end
    total++;
    tick();
    if (w_obs !== {4'b0111, 8'h00}) begin
      $display("FAIL shl_done got=%h exp=%h", w_obs, {4'b0111, 8'h00}); bad++;
    end
    total++;
    tick();
    if (w_obs !== {4'b0011, 8'h00}) begin
      $display("FAIL shl_done_drop got=%h exp=%h", w_obs, {4'b0011, 8'h00}); bad++;
    end
    total++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    if (overflow !== 1'b0) begin
      $display("FAIL ovf_clr got=%b exp=0", overflow); bad++;
    end
    total++;
  endtask

  task automatic test_rotate_right();
    load_row(8'h01);
    send_cmd(1'b0, 4'd3, 1'b1);
    tick();
    if (w_obs !== {4'b1000, 8'h80}) begin
      $display("FAIL rotr_wrap_bit got=%h exp=%h", w_obs, {4'b1000, 8'h80}); bad++;
    end
    total++;
    tick();
    tick();
    if (w_obs !== {4'b0110, 8'h20}) begin
      $display("FAIL rotr_final got=%h exp=%h", w_obs, {4'b0110, 8'h20}); bad++;
    end
    total++;
  endtask

  task automatic test_rotate_wrap();
    load_row(8'h01);
    send_cmd(1'b0, 4'd9, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    if (w_obs !== {4'b1000, 8'h01}) begin
      $display("FAIL rot9_cycle8 got=%h exp=%h", w_obs, {4'b1000, 8'h01}); bad++;
    end
    total++;
    tick();
    if (w_obs !== {4'b0110, 8'h80}) begin
      $display("FAIL rot9_final got=%h exp=%h", w_obs, {4'b0110, 8'h80}); bad++;
    end
    total++;
  endtask

  task automatic test_logical_long();
    load_row(8'h3C);
    send_cmd(1'b0, 4'd10, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    tick();
    if (w_obs !== {4'b0111, 8'h00}) begin
      $display("FAIL shr10_final got=%h exp=%h", w_obs, {4'b0111, 8'h00}); bad++;
    end
    total++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  task automatic test_zero_step();
    load_row(8'h5A);
    send_cmd(1'b1, 4'd0, 1'b0);
    if (w_obs !== {4'b0110, 8'h5A}) begin
      $display("FAIL zero_done got=%h exp=%h", w_obs, {4'b0110, 8'h5A}); bad++;
    end
    total++;
    tick();
    if (w_obs !== {4'b0010, 8'h5A}) begin
      $display("FAIL zero_after got=%h exp=%h", w_obs, {4'b0010, 8'h5A}); bad++;
    end
    total++;
  endtask

  task automatic test_ignored_inputs();
    load_row(8'h0F);
    send_cmd(1'b1, 4'd3, 1'b0);
    cmd_valid  = 1'b1;
    cmd_steps  = 4'd1;
    cmd_dir    = 1'b0;
    mask_set   = 8'hFF;
    #1;
    if (cmd_ready !== 1'b0) begin
      $display("FAIL ready_in_shift got=%b exp=0", cmd_ready); bad++;
    end
    total++;
    tick();
    cmd_valid = 1'b0;
    mask_set  = 8'h00;
    tick();
    tick();
    if (w_obs !== {4'b0110, 8'h78}) begin
      $display("FAIL ignore_final got=%h exp=%h", w_obs, {4'b0110, 8'h78}); bad++;
    end
    total++;
  endtask

  task automatic test_reset_mid_shift();
    load_row(8'h0F);
    send_cmd(1'b1, 4'd5, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    if (w_obs !== {4'b0010, 8'h00}) begin
      $display("FAIL rst_mid_async got=%h exp=%h", w_obs, {4'b0010, 8'h00}); bad++;
    end
    total++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done !== 1'b0) begin
        $display("FAIL rst_mid_no_done got=%b exp=0", done); bad++;
      end
      total++;
    end
    #2;
    reset = 1'b0;
    mask_set = 8'h01;
    send_cmd(1'b1, 4'd1, 1'b0);
    mask_set = 8'h00;
    if (w_obs !== {4'b1000, 8'h01}) begin
      $display("FAIL rst_first_accept got=%h exp=%h", w_obs, {4'b1000, 8'h01}); bad++;
    end
    total++;
    tick();
    if (w_obs !== {4'b0110, 8'h02}) begin
      $display("FAIL rst_new_cmd got=%h exp=%h", w_obs, {4'b0110, 8'h02}); bad++;
    end
    total++;
  endtask

  task automatic test_ovf_race();
    load_row(8'h80);
    send_cmd(1'b1, 4'd1, 1'b0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    if (w_obs !== {4'b0111, 8'h00}) begin
      $display("FAIL ovf_race_set got=%h exp=%h", w_obs, {4'b0111, 8'h00}); bad++;
    end
    total++;
    tick();
    if (overflow !== 1'b1) begin
      $display("FAIL ovf_sticky got=%b exp=1", overflow); bad++;
    end
    total++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    if (overflow !== 1'b0) begin
      $display("FAIL ovf_race_clear got=%b exp=0", overflow); bad++;
    end
    total++;
  endtask

  // scoreboard: busy must never rise across a zero-step command
  logic r_zero_watch = 1'b0;
  int   zero_busy_hits = 0;
  always @(negedge clk) if (r_zero_watch && busy) zero_busy_hits++;

  initial begin
    mask_set   = 8'h00;
    mask_clr   = 8'h00;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_steps  = 4'd0;
    cmd_rotate = 1'b0;
    ovf_clr    = 1'b0;
    test_reset();
    test_mask_priority();
    test_shift_left_ovf();
    test_rotate_right();
    test_rotate_wrap();
    test_logical_long();
    r_zero_watch = 1'b1;
    test_zero_step();
    r_zero_watch = 1'b0;
    if (zero_busy_hits !== 0) begin
      $display("FAIL zero_busy got=%0d exp=0", zero_busy_hits); bad++;
    end
    total++;
    test_ignored_inputs();
    test_reset_mid_shift();
    test_ovf_race();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_row_shifter.md
SNAKE_ROW_SHIFTER -- requirements
Module: snake_row_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the row width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter STEP_W, default 4, giving the width of the shift-step count.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mask_set  input  WIDTH  bits to force to 1 in IDLE cycles.
REQ-006 mask_clr  input  WIDTH  bits to force to 0 in IDLE cycles.
REQ-007 cmd_valid  input  1  shift command request.
REQ-008 cmd_ready  output  1  block can accept a command.
REQ-009 cmd_dir  input  1  direction: 0 = right (toward bit 0), 1 = left (toward bit WIDTH-1).
REQ-010 cmd_steps  input  STEP_W  number of single-bit shifts to perform.
REQ-011 cmd_rotate  input  1  1 = rotate (wrap-around), 0 = logical shift with zero fill.
REQ-012 ovf_clr  input  1  synchronous clear of the overflow flag.
REQ-013 row  output  WIDTH  current row contents (registered).
REQ-014 busy  output  1  high while in SHIFT.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 overflow  output  1  sticky flag: a 1 was shifted off the row edge.

Function
REQ-017 The state machine SHALL have two states, IDLE and SHIFT; cmd_ready = (state==IDLE) and busy = (state==SHIFT).
REQ-018 In every IDLE cycle, row SHALL update to (row & ~mask_clr) | mask_set, so mask_set wins on a bit that is also in mask_clr.
REQ-019 A command SHALL be accepted on an edge where cmd_valid && cmd_ready; at that edge the block SHALL latch cmd_dir, cmd_steps and cmd_rotate.
REQ-020 The IDLE mask update SHALL still apply on the accepting edge.
REQ-021 On acceptance with cmd_steps==0, the block SHALL stay in IDLE and assert done for exactly the next cycle.
REQ-022 On acceptance with cmd_steps=N>0, the block SHALL enter SHIFT and load an internal counter with N.
REQ-023 In SHIFT, each edge SHALL shift row by exactly one bit in the latched direction and decrement the counter.
REQ-024 When the counter reaches 0 in SHIFT, the block SHALL return to IDLE; row then reflects N shifts after acceptance edge + N.
REQ-025 In that case done SHALL be high for exactly the one cycle that follows the edge applying the final shift.
REQ-026 mask_set, mask_clr and cmd_valid SHALL be ignored in SHIFT; cmd_ready SHALL be 0 there.
REQ-027 In rotate mode, the bit leaving one end SHALL re-enter at the opposite end; overflow SHALL be unaffected.
REQ-028 In logical mode, vacated bits SHALL be filled with 0.
REQ-029 In logical mode, overflow SHALL be set if any shifted-out bit is 1.
REQ-030 cmd_steps >= WIDTH SHALL be legal: logical mode yields an all-zero row, and rotate mode wraps modulo WIDTH over N cycles.
REQ-031 ovf_clr SHALL clear overflow on the next edge; if a set event occurs on the same edge, the set SHALL win.
REQ-032 done SHALL be 0 at all times other than those stated in REQ-021 and REQ-025.

Reset
REQ-033 While reset is high, row SHALL be 0, state SHALL be IDLE, the counter SHALL be 0, overflow and done SHALL be 0, and cmd_ready SHALL be 1.
REQ-034 The values in REQ-033 SHALL take effect immediately on reset assertion, without waiting for a clock edge.
REQ-035 Reset asserted mid-SHIFT SHALL abort the command with no done pulse; after release the block SHALL be in IDLE and able to accept a command on the first edge.

Verification
REQ-036 Mask priority: WIDTH=8, IDLE, mask_set=8'h81 and mask_clr=8'h01 for one edge from row=0 -> row=8'h81.
REQ-037 Logical shift left with overflow: row=8'hC0, cmd dir=1, steps=2, rotate=0 accepted -> busy for 2 cycles, row=8'h00, overflow=1, done pulses once, cmd_ready returns to 1.
REQ-038 Rotate right: row=8'h01, dir=0, steps=3, rotate=1 -> row=8'h20 after 3 edges and overflow stays 0.
REQ-038a Rotate wrap: row=8'h01, steps=9, rotate=1 -> row=8'h80.
REQ-039 Zero-step command and ignored inputs: cmd_steps=0 accepted -> done high the next cycle and busy never asserted; cmd_valid and mask_set pulsed during SHIFT -> no effect.
REQ-040 Reset mid-shift: reset asserted on the 2nd cycle of a 5-step shift -> row=0 immediately, no done; a new command accepted on the first edge after release.
REQ-041 Overflow clear race: ovf_clr on the same edge as a 1 bit shifted out -> overflow=1; ovf_clr alone on a later edge -> overflow=0.
